// File: rtl/karplus_strong_pkg.sv
// Shared types and constants for the Karplus-Strong plucked-string voice.
package karplus_strong_pkg;

  // Default sample and delay-line widths.
  localparam int KS_DATA_W = 16;
  localparam int KS_ADDR_W = 12;

  // Noise generator reset value; must never be zero or the LFSR locks up.
  localparam logic [15:0] KS_LFSR_SEED = 16'hACE1;

  // Taps x^16 + x^14 + x^13 + x^11 map onto state bits 15, 13, 12 and 10.
  localparam logic [15:0] KS_LFSR_TAPS = 16'hB400;

  // Voice sequencing: idle until plucked, fill the string with noise, then ring.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } ks_state_t;

  // One step of the left-shifting Fibonacci LFSR; feedback lands in bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & KS_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/karplus_strong_lfsr.sv
// 16-bit Fibonacci LFSR supplying the excitation noise for each pluck.
module ks_lfsr
  import karplus_strong_pkg::*;
#(
  parameter logic [15:0] SEED = KS_LFSR_SEED
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic        enable,
  output logic [15:0] state
);

  // Advance one position per enabled clock; the seed is restored only by reset.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= SEED;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/karplus_strong.sv
// Karplus-Strong plucked-string synthesizer: a noise-filled delay line
// recirculated through a one-pole low-pass whose strength is set by cutoff.
module karplus_strong
  import karplus_strong_pkg::*;
#(
  parameter int          DATA_W    = KS_DATA_W,
  parameter int          ADDR_W    = KS_ADDR_W,
  parameter logic [15:0] LFSR_SEED = KS_LFSR_SEED
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              clk_sample,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] tone,
  input  logic [2:0]        cutoff,
  output logic [DATA_W-1:0] sample
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LEN_MIN = ADDR_W'(2);

  ks_state_t         state;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] y_prev;
  logic              cs_d;
  logic              read_pend;
  logic              calc_pend;

  logic              sample_edge;
  logic              ptr_at_end;
  logic              lfsr_en;
  logic [15:0]       lfsr_q;
  logic [DATA_W-1:0] fill_word;

  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] ram [0:DEPTH-1];

  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] step;
  logic [DATA_W-1:0]      y_next;

  // Noise source; it only moves while the string is being filled.
  ks_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .aclr   (aclr),
    .enable (lfsr_en),
    .state  (lfsr_q)
  );

  // Noise words narrower than 16 bits keep the low bits; wider ones are zero-extended.
  generate
    if (DATA_W <= 16) begin : g_fill_narrow
      assign fill_word = lfsr_q[DATA_W-1:0];
    end else begin : g_fill_wide
      assign fill_word = {{(DATA_W-16){1'b0}}, lfsr_q};
    end
  endgenerate

  assign sample_edge = clk_sample & ~cs_d;
  assign ptr_at_end  = (ptr == (len - PTR_ONE));

  // A trigger takes priority everywhere, so it suppresses every RAM access and
  // noise step on the clock where it is seen; that is what aborts a pending step.
  assign lfsr_en   = (state == FILL) && !trigger;
  assign ram_we    = !trigger && ((state == FILL) || calc_pend);
  assign ram_re    = !trigger && read_pend;
  assign ram_wdata = (state == FILL) ? fill_word : y_next;

  // Loop filter: move y_prev toward the delayed sample by (x - y_prev) >>> cutoff.
  // The extra difference bit keeps the subtraction exact; the sum always fits back
  // in DATA_W because the result lies between x and y_prev.
  always_comb begin
    diff   = $signed({ram_q[DATA_W-1], ram_q}) - $signed({y_prev[DATA_W-1], y_prev});
    step   = diff >>> cutoff;
    y_next = DATA_W'($signed({y_prev[DATA_W-1], y_prev}) + step);
  end

  // Single-port delay line; reads and writes share ptr and are never in the same cycle.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ptr] <= ram_wdata;
    end
    if (ram_re) begin
      ram_q <= ram[ptr];
    end
  end

  // Voice sequencer: pluck handling, fill pointer, and the edge/read/compute pipeline.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state     <= IDLE;
      len       <= LEN_MIN;
      ptr       <= '0;
      y_prev    <= '0;
      sample    <= '0;
      cs_d      <= 1'b0;
      read_pend <= 1'b0;
      calc_pend <= 1'b0;
    end else begin
      cs_d <= clk_sample;
      if (trigger) begin
        len       <= (tone < LEN_MIN) ? LEN_MIN : tone;
        ptr       <= '0;
        y_prev    <= '0;
        sample    <= '0;
        read_pend <= 1'b0;
        calc_pend <= 1'b0;
        state     <= FILL;
      end else begin
        case (state)
          IDLE: begin
            read_pend <= 1'b0;
            calc_pend <= 1'b0;
          end
          FILL: begin
            read_pend <= 1'b0;
            calc_pend <= 1'b0;
            if (ptr_at_end) begin
              ptr   <= '0;
              state <= RUN;
            end else begin
              ptr <= ptr + PTR_ONE;
            end
          end
          RUN: begin
            read_pend <= sample_edge;
            calc_pend <= read_pend;
            if (calc_pend) begin
              sample <= y_next;
              y_prev <= y_next;
              ptr    <= ptr_at_end ? '0 : (ptr + PTR_ONE);
            end
          end
          default: begin
            read_pend <= 1'b0;
            calc_pend <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_karplus_strong.sv
// Self-checking bench for karplus_strong against a ring-buffer reference model.
module tb_karplus_strong;

  logic        clk;
  logic        aclr;
  logic        clk_sample;
  logic        trigger;
  logic [11:0] tone;
  logic [2:0]  cutoff;
  logic [15:0] sample;

  int total;
  int bad;

  // Reference model: the string as an array of integers plus the noise generator.
  int          m_buf [4096];
  int          m_len;
  int          m_idx;
  int          m_y;
  logic [15:0] m_lfsr;
  bit          m_running;

  typedef struct {
    logic [2:0]  cut;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  karplus_strong #(
    .DATA_W    (16),
    .ADDR_W    (12),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .clk_sample (clk_sample),
    .trigger    (trigger),
    .tone       (tone),
    .cutoff     (cutoff),
    .sample     (sample)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] noise_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic model_reset();
    m_lfsr    = 16'hACE1;
    m_y       = 0;
    m_len     = 2;
    m_idx     = 0;
    m_running = 1'b0;
  endtask

  task automatic model_pluck(input int t);
    m_len = (t < 2) ? 2 : t;
    for (int i = 0; i < m_len; i++) begin
      m_buf[i] = int'($signed(m_lfsr));
      m_lfsr   = noise_next(m_lfsr);
    end
    m_idx     = 0;
    m_y       = 0;
    m_running = 1'b1;
  endtask

  task automatic model_step(input int c);
    int x;
    x = m_buf[m_idx];
    m_y = m_y + ((x - m_y) >>> c);
    m_buf[m_idx] = m_y;
    m_idx = (m_idx + 1) % m_len;
  endtask

  // One clk_sample period: high 4 clocks, then low for 'low' clocks.
  task automatic apply_stimulus(input logic [2:0] cut, input int low);
    cutoff     = cut;
    clk_sample = 1'b1;
    tick();
    tick();
    check_output("hold_before_step", sample, 16'(m_y));
    tick();
    if (m_running) model_step(int'(cut));
    check_output("step_result", sample, 16'(m_y));
    tick();
    clk_sample = 1'b0;
    repeat (low) tick();
  endtask

  // Caller positions time away from the clock edge; reset acts without a clock.
  task automatic reset_now();
    aclr = 1'b0;
    #1;
    check_output("reset_async_sample", sample, 16'h0000);
    tick();
    tick();
    aclr = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic pluck(input logic [11:0] t);
    trigger = 1'b1;
    tone    = t;
    tick();
    trigger = 1'b0;
    tone    = 12'($urandom);
    check_output("pluck_clears_sample", sample, 16'h0000);
    model_pluck(int'(t));
    repeat (m_len) tick();
  endtask

  initial begin
    int init_peak;
    int last_peak;
    int a;
    int steps;
    logic [11:0] rt;

    total      = 0;
    bad        = 0;
    aclr       = 1'b1;
    clk_sample = 1'b0;
    trigger    = 1'b0;
    tone       = '0;
    cutoff     = '0;
    model_reset();

    #3;
    reset_now();

    $display("[TB] edges while idle");
    apply_stimulus(3'd0, 4);
    apply_stimulus(3'd1, 4);

    $display("[TB] tone=4 cutoff=0 delay loop");
    vecs[0] = '{3'd0, 16'hACE1};
    vecs[1] = '{3'd0, 16'h59C3};
    vecs[2] = '{3'd0, 16'hB387};
    vecs[3] = '{3'd0, 16'h670F};
    vecs[4] = '{3'd0, 16'hACE1};
    vecs[5] = '{3'd0, 16'h59C3};
    vecs[6] = '{3'd0, 16'hB387};
    vecs[7] = '{3'd0, 16'h670F};
    pluck(12'd4);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].cut, 4);
      check_output("table_sequence", sample, vecs[i].exp);
    end

    $display("[TB] tone=2 cutoff=1 averaging");
    pluck(12'd2);
    for (int i = 0; i < 6; i++) apply_stimulus(3'd1, 4);

    $display("[TB] tone=0 and tone=1 clamp to length 2");
    pluck(12'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(3'd0, 4);
    pluck(12'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(3'd0, 5);
    for (int i = 0; i < 3; i++) apply_stimulus(3'd2, 4);

    $display("[TB] edge during last fill cycle is ignored");
    trigger = 1'b1;
    tone    = 12'd2;
    tick();
    trigger = 1'b0;
    model_pluck(2);
    tick();
    clk_sample = 1'b1;
    repeat (4) tick();
    check_output("fill_edge_ignored", sample, 16'h0000);
    clk_sample = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) apply_stimulus(3'd0, 4);

    $display("[TB] trigger aborts an in-flight step");
    pluck(12'd5);
    for (int i = 0; i < 3; i++) apply_stimulus(3'd1, 4);
    cutoff     = 3'd1;
    clk_sample = 1'b1;
    tick();
    tick();
    trigger = 1'b1;
    tone    = 12'd7;
    tick();
    trigger = 1'b0;
    tone    = 12'($urandom);
    check_output("abort_clears_sample", sample, 16'h0000);
    model_pluck(7);
    tick();
    clk_sample = 1'b0;
    repeat (6) tick();
    check_output("abort_fill_hold", sample, 16'h0000);
    for (int i = 0; i < 14; i++) apply_stimulus(3'd0, 4);

    $display("[TB] randomized plucks");
    for (int p = 0; p < 6; p++) begin
      rt = 12'($urandom_range(0, 24));
      pluck(rt);
      steps = $urandom_range(m_len, 3 * m_len);
      for (int i = 0; i < steps; i++) begin
        tone = 12'($urandom);
        apply_stimulus(3'($urandom_range(0, 7)), $urandom_range(4, 7));
      end
    end

    $display("[TB] reset mid-run");
    pluck(12'd9);
    for (int i = 0; i < 3; i++) apply_stimulus(3'd0, 4);
    tick();
    #2;
    reset_now();
    apply_stimulus(3'd0, 4);
    apply_stimulus(3'd1, 4);

    $display("[TB] reset mid-fill");
    trigger = 1'b1;
    tone    = 12'd20;
    tick();
    trigger = 1'b0;
    repeat (5) tick();
    #2;
    reset_now();
    apply_stimulus(3'd0, 4);
    apply_stimulus(3'd0, 4);
    pluck(12'd3);
    for (int i = 0; i < 3; i++) apply_stimulus(3'd0, 4);
    check_output("seed_restored_after_reset", sample, 16'hB387);

    $display("[TB] long decay run, cutoff=7");
    pluck(12'h555);
    init_peak = 0;
    for (int i = 0; i < m_len; i++) begin
      a = (m_buf[i] < 0) ? -m_buf[i] : m_buf[i];
      if (a > init_peak) init_peak = a;
    end
    last_peak = 0;
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(3'd7, 4);
      if (i >= 3000 - m_len) begin
        a = int'($signed(sample));
        if (a < 0) a = -a;
        if (a > last_peak) last_peak = a;
      end
    end
    total++;
    if (last_peak >= init_peak) begin
      bad++;
      $display("[TB] FAIL decay_peak: got %0d required below %0d", last_peak, init_peak);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
